// File: rtl/seconds_display_pkg.sv
// Shared constants for the seconds display: active-low segment patterns,
// converter state encoding and the double-dabble nibble adjust helper.
package seconds_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    DISP_IDLE   = 2'd0,
    DISP_SHIFT  = 2'd1,
    DISP_UPDATE = 2'd2
  } disp_state_t;

  // A nibble of 5 or more would overflow past 9 once doubled, so pre-add 3.
  function automatic logic [3:0] add3(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

endpackage

// File: rtl/seconds_display_bcd_to_seg7.sv
// One BCD digit to an active-low seven-segment pattern (bit 0 = a .. bit 6 = g).
// Codes above 9 and an asserted blank both give a dark digit.
module bcd_to_seg7
  import seconds_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seconds_display.sv
// Binary seconds count -> BCD via a sequential double-dabble engine, driving
// DIGITS active-low seven-segment displays with optional leading-zero blanking.
module seconds_display
  import seconds_display_pkg::*;
#(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 4
) (
  input  logic                   clk,
  input  logic                   async_reset,
  input  logic [BIN_WIDTH-1:0]   bin_value,
  input  logic                   blank_leading_zeros,
  output logic [7*DIGITS-1:0]    hex_out,
  output logic                   busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  // Handshake: none. bin_value is sampled only while idle; changes during a
  // conversion are picked up by the last_value compare on the next idle edge.
  disp_state_t          state;
  logic                 pending;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [BIN_WIDTH-1:0] last_value;
  logic [BCD_W-1:0]     bcd_work;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     digit_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DIGITS-1:0]    blank_vec;
  logic                 upper_zero;

  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = add3(bcd_work[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state      <= DISP_IDLE;
      pending    <= 1'b1;
      shift_reg  <= '0;
      last_value <= '0;
      bcd_work   <= '0;
      digit_q    <= '0;
      bit_cnt    <= '0;
    end else begin
      case (state)
        DISP_IDLE: begin
          if (pending || (bin_value != last_value)) begin
            shift_reg  <= bin_value;
            last_value <= bin_value;
            bcd_work   <= '0;
            pending    <= 1'b0;
            bit_cnt    <= CNT_W'(BIN_WIDTH);
            state      <= DISP_SHIFT;
          end
        end
        DISP_SHIFT: begin
          {bcd_work, shift_reg} <= {bcd_adj, shift_reg} << 1;
          bit_cnt <= bit_cnt - CNT_W'(1);
          if (bit_cnt == CNT_W'(1)) state <= DISP_UPDATE;
        end
        DISP_UPDATE: begin
          digit_q <= bcd_work;
          state   <= DISP_IDLE;
        end
        default: state <= DISP_IDLE;
      endcase
    end
  end

  assign busy = (state != DISP_IDLE);

  // Walk down from the most significant digit; a digit is leading only while
  // it and every digit above it are zero. Digit 0 always shows.
  always_comb begin
    blank_vec  = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero   = upper_zero && (digit_q[4*i +: 4] == 4'd0);
      blank_vec[i] = blank_leading_zeros && upper_zero;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_to_seg7 u_seg (
      .digit (digit_q[4*g +: 4]),
      .blank (blank_vec[g]),
      .seg   (hex_out[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_seconds_display.sv
// Bench for seconds_display: directed vector table, hand-written corner
// sequences and random stimulus, all checked against a decimal-arithmetic model.
module tb_seconds_display;

  localparam int BIN_WIDTH = 8;
  localparam int DIGITS    = 4;
  localparam int HW        = 7 * DIGITS;
  localparam int LAT       = BIN_WIDTH + 1;

  logic                 clk = 1'b0;
  logic                 async_reset;
  logic [BIN_WIDTH-1:0] bin_value;
  logic                 blank_leading_zeros;
  logic [HW-1:0]        hex_out;
  logic                 busy;

  always #5 clk = ~clk;

  seconds_display #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk                 (clk),
    .async_reset         (async_reset),
    .bin_value           (bin_value),
    .blank_leading_zeros (blank_leading_zeros),
    .hex_out             (hex_out),
    .busy                (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: cycles left in the current conversion, last captured value,
  // value being converted and value on the display.
  int m_cnt, m_last, m_conv, m_disp;
  bit m_pending, m_in_reset;

  logic [HW-1:0] exp_q[$];

  typedef struct {
    int            bin;
    logic          blk;
    logic [HW-1:0] exp;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [HW-1:0] exp_hex(int n, logic blk);
    logic [HW-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i > 0 && blk && n < p) r[7*i +: 7] = 7'h7F;
      else r[7*i +: 7] = seg_of((n / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_last = 0; m_conv = 0; m_disp = 0; m_pending = 1'b1;
  endtask

  task automatic model_edge();
    if (m_in_reset) return;
    if (m_cnt == 0) begin
      if (m_pending || int'(bin_value) != m_last) begin
        m_conv = int'(bin_value);
        m_last = int'(bin_value);
        m_pending = 1'b0;
        m_cnt = LAT;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) m_disp = m_conv;
    end
  endtask

  task automatic check_outputs();
    check("hex", 32'(hex_out), 32'(exp_hex(m_disp, blank_leading_zeros)));
    check("busy", 32'(busy), 32'(m_cnt != 0));
  endtask

  // Ends at a negedge with outputs checked; inputs may be changed right after.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_idle(int max_cycles);
    for (int i = 0; i < max_cycles && busy; i++) cycle();
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int busy_len;
    logic [HW-1:0] prev;

    vecs[0] = '{123, 1'b0, {7'h40, 7'h79, 7'h24, 7'h30}};
    vecs[1] = '{255, 1'b1, {7'h7F, 7'h24, 7'h12, 7'h12}};
    vecs[2] = '{  7, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}};
    vecs[3] = '{  0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[4] = '{ 42, 1'b0, {7'h40, 7'h40, 7'h19, 7'h24}};
    vecs[5] = '{ 42, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h24}};
    vecs[6] = '{100, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40}};
    vecs[7] = '{200, 1'b0, {7'h40, 7'h24, 7'h40, 7'h40}};
    vecs[8] = '{  9, 1'b0, {7'h40, 7'h40, 7'h40, 7'h10}};

    // Reset with zero input: all digits show 0, then one conversion of 9 cycles.
    async_reset = 1'b0;
    bin_value = '0;
    blank_leading_zeros = 1'b0;
    m_in_reset = 1'b1;
    model_reset();
    #1;
    check("reset_hex", 32'(hex_out), 32'({4{7'h40}}));
    check("reset_busy", 32'(busy), 32'd0);
    cycle();
    cycle();
    async_reset = 1'b1;
    m_in_reset = 1'b0;
    busy_len = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (busy) busy_len++;
      else if (busy_len > 0) break;
    end
    check("post_reset_busy_len", 32'(busy_len), 32'(LAT));
    check("post_reset_hex", 32'(hex_out), 32'({4{7'h40}}));

    // Directed vectors: each settles and holds with no further conversion.
    for (int v = 0; v < 9; v++) begin
      bin_value = BIN_WIDTH'(vecs[v].bin);
      blank_leading_zeros = vecs[v].blk;
      cycle();
      wait_idle(20);
      cycle();
      cycle();
      check("vec_hex", 32'(hex_out), 32'(vecs[v].exp));
    end

    // Input change on the third busy cycle: only final patterns may appear.
    exp_q.push_back({7'h40, 7'h40, 7'h79, 7'h40});
    exp_q.push_back({7'h40, 7'h40, 7'h10, 7'h10});
    prev = hex_out;
    bin_value = 8'd10;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (hex_out !== prev) begin
        if (exp_q.size() == 0) check("seq_extra_change", 32'(hex_out), 32'(prev));
        else check("seq_hex", 32'(hex_out), 32'(exp_q.pop_front()));
        prev = hex_out;
      end
    end
    bin_value = 8'd99;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (hex_out !== prev) begin
        if (exp_q.size() == 0) check("seq_extra_change", 32'(hex_out), 32'(prev));
        else check("seq_hex", 32'(hex_out), 32'(exp_q.pop_front()));
        prev = hex_out;
      end
    end
    check("seq_all_seen", 32'(exp_q.size()), 32'd0);
    check("seq_final", 32'(hex_out), 32'({7'h40, 7'h40, 7'h10, 7'h10}));

    // Reset in the middle of a shift sequence, blanking enabled.
    blank_leading_zeros = 1'b1;
    bin_value = 8'd200;
    for (int i = 0; i < 4; i++) cycle();
    check("midshift_busy", 32'(busy), 32'd1);
    #2;
    async_reset = 1'b0;
    m_in_reset = 1'b1;
    model_reset();
    #1;
    check("midreset_hex", 32'(hex_out), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
    check("midreset_busy", 32'(busy), 32'd0);
    cycle();
    cycle();
    async_reset = 1'b1;
    m_in_reset = 1'b0;
    cycle();
    wait_idle(20);
    check("after_reset_hex", 32'(hex_out), 32'({7'h7F, 7'h24, 7'h40, 7'h40}));

    // Blanking toggle acts immediately without a conversion.
    bin_value = 8'd42;
    blank_leading_zeros = 1'b0;
    cycle();
    wait_idle(20);
    for (int i = 0; i < 4; i++) begin
      blank_leading_zeros = ~blank_leading_zeros;
      #1;
      check("toggle_hex", 32'(hex_out),
            blank_leading_zeros ? 32'({7'h7F, 7'h7F, 7'h19, 7'h24})
                                : 32'({7'h40, 7'h40, 7'h19, 7'h24}));
      check("toggle_busy", 32'(busy), 32'd0);
      cycle();
    end

    // Random stimulus against the model, including boundary values.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       bin_value = 8'd0;
          1:       bin_value = 8'd255;
          default: bin_value = BIN_WIDTH'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 15) == 0) blank_leading_zeros = ~blank_leading_zeros;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
